// File: rtl/sum_pkg.sv
// Shared types and constants for the summing-thread consumer stage.
package sum_pkg;

  localparam int SUM_WIDTH     = 8;
  localparam int SUM_BUF_DEPTH = 4;

  typedef logic [SUM_WIDTH-1:0]             sum_t;
  typedef logic [$clog2(SUM_BUF_DEPTH):0]   buf_ptr_t;

  // Control view of the buffer, decoded from the pointers each cycle.
  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'd0,
    BUF_PARTIAL = 2'd1,
    BUF_FULL    = 2'd2
  } buf_state_e;

endpackage

// File: rtl/sum_rise_det.sv
// Rising-edge detector on the load strobe: one capture per load high period.
module sum_rise_det (
  input  logic ck,
  input  logic reset_l,
  input  logic load_i,
  output logic cap_o
);

  logic load_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) load_q <= 1'b0;
    else          load_q <= load_i;
  end

  assign cap_o = load_i & ~load_q;

endmodule

// File: rtl/sum_buffer_stage.sv
// Circular FIFO capturing completed sums and presenting them over valid/ready.
// Define SUM_BUF_OVF_CNT_EN to add the saturating ovf_count port.
module sum_buffer_stage
  import sum_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH,
  parameter int DEPTH = SUM_BUF_DEPTH
) (
  input  logic                       ck,
  input  logic                       reset_l,
  input  logic                       load,
  input  logic [WIDTH-1:0]           potVal,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       dropped
`ifdef SUM_BUF_OVF_CNT_EN
  ,
  output logic [7:0]                 ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic             cap;
  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    fill;
  logic             dropped_q, dropped_d;
  buf_state_e       state;
  logic [WIDTH-1:0] mem [DEPTH];

  sum_rise_det u_rise_det (
    .ck      (ck),
    .reset_l (reset_l),
    .load_i  (load),
    .cap_o   (cap)
  );

  // Pointer MSB differs when wrapped, so the difference spans 0..DEPTH.
  assign fill = wr_ptr_q - rd_ptr_q;

  always_comb begin
    state = BUF_PARTIAL;
    if (fill == '0)              state = BUF_EMPTY;
    else if (fill == PW'(DEPTH)) state = BUF_FULL;
  end

  assign out_valid = (state != BUF_EMPTY);
  assign full      = (state == BUF_FULL);
  assign count     = fill;
  assign out_data  = out_valid ? mem[rd_ptr_q[AW-1:0]] : '0;

  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign pop  = out_valid & out_ready;
  assign push = cap & (~full | pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    dropped_d = dropped_q | (cap & full & ~pop);
  end

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dropped_q <= dropped_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= potVal;
  end

  assign dropped = dropped_q;

`ifdef SUM_BUF_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l)                            ovf_q <= 8'd0;
    else if (cap & full & ~pop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_sum_buffer_stage.sv
// Directed self-checking bench for sum_buffer_stage.
module tb_sum_buffer_stage;

  logic       ck = 1'b0;
  logic       reset_l;
  logic       load;
  logic [7:0] potVal;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       full;
  logic       dropped;
`ifdef SUM_BUF_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  sum_buffer_stage dut (
    .ck        (ck),
    .reset_l   (reset_l),
    .load      (load),
    .potVal    (potVal),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .dropped   (dropped)
`ifdef SUM_BUF_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    load   = 1'b1;
    potVal = v;
    tick();
    load   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_l = 1'b0; load = 1'b0; potVal = 8'h00; out_ready = 1'b0;
    #12;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", out_data); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else pass_cnt++;
    total_cnt++; if (dropped !== 1'b0) $display("FAIL reset_dropped got %b exp 0", dropped); else pass_cnt++;
`ifdef SUM_BUF_OVF_CNT_EN
    total_cnt++; if (ovf_count !== 8'd0) $display("FAIL reset_ovf got %0d exp 0", ovf_count); else pass_cnt++;
`endif
    tick();
    reset_l = 1'b1;
    tick();
  endtask

  task automatic test_single();
    load = 1'b1; potVal = 8'h2A;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h2A) $display("FAIL single_data got %h exp 2a", out_data); else pass_cnt++;
    total_cnt++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else pass_cnt++;
    load = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_pop_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL single_pop_data got %h exp 00", out_data); else pass_cnt++;
    // out_ready while empty must not disturb the pointers
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL empty_ready_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_hold();
    load = 1'b1; potVal = 8'h10;
    repeat (5) tick();
    load = 1'b0;
    tick();
    total_cnt++; if (count !== 3'd1) $display("FAIL hold_count got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h10) $display("FAIL hold_data got %h exp 10", out_data); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL hold_drain_count got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h77};
    pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
    total_cnt++; if (full !== 1'b1) $display("FAIL fpp_full got %b exp 1", full); else pass_cnt++;
    load = 1'b1; potVal = 8'h77; out_ready = 1'b1;
    tick();
    load = 1'b0; out_ready = 1'b0;
    total_cnt++; if (count !== 3'd4) $display("FAIL fpp_count got %0d exp 4", count); else pass_cnt++;
    total_cnt++; if (dropped !== 1'b0) $display("FAIL fpp_dropped got %b exp 0", dropped); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (out_data !== exp_q[i]) $display("FAIL fpp_drain%0d got %h exp %h", i, out_data, exp_q[i]); else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL fpp_empty got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse(8'h01); pulse(8'h02); pulse(8'h03); pulse(8'h04);
    total_cnt++; if (dropped !== 1'b0) $display("FAIL ovf_pre_dropped got %b exp 0", dropped); else pass_cnt++;
    pulse(8'h05);
    total_cnt++; if (full !== 1'b1) $display("FAIL ovf_full got %b exp 1", full); else pass_cnt++;
    total_cnt++; if (dropped !== 1'b1) $display("FAIL ovf_dropped got %b exp 1", dropped); else pass_cnt++;
    total_cnt++; if (count !== 3'd4) $display("FAIL ovf_count_val got %0d exp 4", count); else pass_cnt++;
`ifdef SUM_BUF_OVF_CNT_EN
    total_cnt++; if (ovf_count !== 8'd1) $display("FAIL ovf_counter got %0d exp 1", ovf_count); else pass_cnt++;
`endif
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL ovf_drain_valid%0d got %b exp 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 8'(i)) $display("FAIL ovf_drain%0d got %h exp %h", i, out_data, 8'(i)); else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf_end_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL ovf_end_data got %h exp 00", out_data); else pass_cnt++;
    total_cnt++; if (dropped !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", dropped); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      load = 1'b1; potVal = 8'hA0 + 8'(i);
      tick();
      load = 1'b0;
      total_cnt++; if (out_data !== 8'hA0 + 8'(i)) $display("FAIL wrap%0d_data got %h exp %h", i, out_data, 8'hA0 + 8'(i)); else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total_cnt++; if (count !== 3'd0) $display("FAIL wrap%0d_count got %0d exp 0", i, count); else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    pulse(8'h31); pulse(8'h32); pulse(8'h33);
    total_cnt++; if (count !== 3'd3) $display("FAIL mr_pre_count got %0d exp 3", count); else pass_cnt++;
    #2;
    reset_l = 1'b0;
    load = 1'b1; potVal = 8'h5C;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL mr_async_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL mr_async_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (dropped !== 1'b0) $display("FAIL mr_dropped got %b exp 0", dropped); else pass_cnt++;
    tick();
    reset_l = 1'b1;
    tick();
    load = 1'b0;
    total_cnt++; if (count !== 3'd1) $display("FAIL mr_post_count got %0d exp 1", count); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h5C) $display("FAIL mr_post_data got %h exp 5c", out_data); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_full_push_pop();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
